// File: rtl/store_merge_pkg.sv
// Shared encodings for the store merge unit and the load-side extractor.
// Store types, load types and store FSM states.
package store_merge_pkg;

  typedef enum logic [1:0] {
    ST_WORD = 2'd0,
    ST_BYTE = 2'd1,
    ST_HALF = 2'd2,
    ST_RSVD = 2'd3
  } st_type_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LH  = 3'd2,
    LD_LBU = 3'd3,
    LD_LHU = 3'd4
  } ld_type_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  function automatic logic misaligned(
    input st_type_e   kind,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    unique case (kind)
      ST_WORD: bad = (off != 2'd0);
      ST_HALF: bad = off[0];
      ST_BYTE: bad = 1'b0;
      ST_RSVD: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: inserts a byte/half/word into an old word.
// Ports: old_word, data, kind, offset in; merged word out.
module store_lane_merge
  import store_merge_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  st_type_e    kind,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    unique case (kind)
      ST_WORD: merged = data;
      ST_BYTE: begin
        unique case (offset)
          2'd0: merged[7:0]   = data[7:0];
          2'd1: merged[15:8]  = data[7:0];
          2'd2: merged[23:16] = data[7:0];
          2'd3: merged[31:24] = data[7:0];
        endcase
      end
      ST_HALF: begin
        if (offset[1]) merged[31:16] = data[15:0];
        else           merged[15:0]  = data[15:0];
      end
      ST_RSVD: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_merge.sv
// Sub-word store unit: read-modify-write for sb/sh, direct write for sw.
// Ports: req_* handshake in, mem_* word port out, done/align_err pulses.
module store_merge
  import store_merge_pkg::*;
#(
  parameter int TYPE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [TYPE_W-1:0] req_type,
  output logic [31:0]       mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              align_err
);

  state_e      state;
  st_type_e    kind_in;
  st_type_e    kind_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] merge_q;

  always_comb begin
    kind_in = ST_RSVD;
    if (req_type == TYPE_W'(ST_WORD))
      kind_in = ST_WORD;
    else if (req_type == TYPE_W'(ST_BYTE))
      kind_in = ST_BYTE;
    else if (req_type == TYPE_W'(ST_HALF))
      kind_in = ST_HALF;
  end

  assign req_ready = (state == S_IDLE);
  // Address only changes on acceptance, so it holds READ..WRITE.
  assign mem_addr  = {addr_q[31:2], 2'b00};

  // Word stores bypass merge_q: the merge returns data_q whole.
  store_lane_merge u_merge (
    .old_word (merge_q),
    .data     (data_q),
    .kind     (kind_q),
    .offset   (addr_q[1:0]),
    .merged   (mem_wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      kind_q    <= ST_WORD;
      addr_q    <= '0;
      data_q    <= '0;
      merge_q   <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      align_err <= 1'b0;
    end else begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      align_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            data_q <= req_data;
            kind_q <= kind_in;
            if (misaligned(kind_in, req_addr[1:0])) begin
              state     <= S_ERR;
              align_err <= 1'b1;
            end else if (kind_in == ST_WORD) begin
              state  <= S_WRITE;
              mem_we <= 1'b1;
              done   <= 1'b1;
            end else begin
              state  <= S_READ;
              mem_re <= 1'b1;
            end
          end
        end
        S_READ: state <= S_WAIT;
        S_WAIT: begin
          if (mem_rvalid) begin
            merge_q <= mem_rdata;
            state   <= S_WRITE;
            mem_we  <= 1'b1;
            done    <= 1'b1;
          end
        end
        S_WRITE: state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge.sv
// Scoreboard bench for store_merge: directed stores, monitor checks writes.
// Expected events are queued by stimulus and popped by a negedge monitor.
module tb_store_merge;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_type;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        done;
  logic        align_err;

  store_merge #(.TYPE_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_type   (req_type),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .done       (done),
    .align_err  (align_err)
  );

  typedef struct {
    bit          err;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t sb[$];
  ev_t mon_ev;
  int  passed = 0;
  int  total  = 0;
  int  cyc    = 0;
  int  re_cnt = 0;
  int  we_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_re) re_cnt++;
      if (mem_we) we_cnt++;
      if (mem_we || align_err) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_event: we=%b err=%b addr %h data %h",
                   mem_we, align_err, mem_addr, mem_wdata);
        end else begin
          mon_ev = sb.pop_front();
          chk("event_is_err", 32'(align_err), 32'(mon_ev.err));
          chk("latency", 32'(cyc), 32'(mon_ev.cyc));
          if (mon_ev.err) begin
            chk("err_ready_low", 32'(req_ready), 32'd0);
            chk("err_no_we", 32'(mem_we), 32'd0);
          end else begin
            chk("mem_addr", mem_addr, mon_ev.addr);
            chk("mem_wdata", mem_wdata, mon_ev.data);
            chk("done", 32'(done), 32'd1);
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Called at the negedge of the READ cycle; rvalid lands in WAIT cycle waitn.
  task automatic serve_read(input logic [31:0] rdata, input int waitn,
                            input bit junk);
    mem_rvalid = junk;
    mem_rdata  = junk ? 32'hDEADDEAD : 32'h0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (waitn - 1) @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] t, input logic [31:0] rdata,
                       input int waitn, input bit err,
                       input logic [31:0] ea, input logic [31:0] ed,
                       input bit junk);
    int  re0;
    int  lat;
    ev_t e;
    re0 = re_cnt;
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_type  = t;
    lat = (err || t == 2'd0) ? 1 : 2 + waitn;
    e.err  = err;
    e.addr = ea;
    e.data = ed;
    e.cyc  = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_data  = 32'hBAD0_BAD0;
    req_type  = 2'd0;
    if (!err && t != 2'd0) serve_read(rdata, waitn, junk);
    drain();
    chk("mem_re_count", 32'(re_cnt - re0),
        (err || t == 2'd0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ev_t e;
    int  we0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    req_type   = '0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_pulses", {28'd0, mem_re, mem_we, done, align_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    store(32'h100, 32'hDEADBEEF, 2'd0, 0, 0, 0, 32'h100, 32'hDEADBEEF, 0);
    store(32'h103, 32'h000000AA, 2'd1, 32'h11223344, 2, 0,
          32'h100, 32'hAA223344, 0);
    store(32'h202, 32'h0000BEEF, 2'd2, 32'h11223344, 1, 0,
          32'h200, 32'hBEEF3344, 0);
    store(32'h200, 32'h0000BEEF, 2'd2, 32'h11223344, 1, 0,
          32'h200, 32'h1122BEEF, 1);
    store(32'h201, 32'h0000BEEF, 2'd2, 0, 0, 1, 0, 0, 0);
    store(32'h102, 32'h12345678, 2'd0, 0, 0, 1, 0, 0, 0);
    store(32'h100, 32'h12345678, 2'd3, 0, 0, 1, 0, 0, 0);
    store(32'h101, 32'h00000055, 2'd1, 32'hAABBCCDD, 3, 0,
          32'h100, 32'hAABB55DD, 0);
    store(32'h104, 32'h123456FF, 2'd1, 32'h00000000, 1, 0,
          32'h104, 32'h000000FF, 0);
    store(32'h10A, 32'hA5A55A5A, 2'd2, 32'hFFFFFFFF, 1, 0,
          32'h108, 32'h5A5AFFFF, 0);
    store(32'hFFFFFFFC, 32'h0BADF00D, 2'd0, 0, 0, 0,
          32'hFFFFFFFC, 32'h0BADF00D, 0);

    // Reset while waiting for read data, then a stale rvalid.
    we0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h400;
    req_data  = 32'h11;
    req_type  = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rstwait_ready", 32'(req_ready), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55555555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstwait_no_we", 32'(we_cnt - we0), 32'd0);
    chk("rstwait_idle", 32'(req_ready), 32'd1);

    // Back-to-back: sw then sb with req_valid held high.
    we0 = we_cnt;
    req_valid = 1'b1;
    req_addr  = 32'h300;
    req_data  = 32'hCAFEF00D;
    req_type  = 2'd0;
    e.err  = 0;
    e.addr = 32'h300;
    e.data = 32'hCAFEF00D;
    e.cyc  = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    chk("b2b_ready_write", 32'(req_ready), 32'd0);
    req_addr = 32'h301;
    req_data = 32'h0000005A;
    req_type = 2'd1;
    @(negedge clk);
    chk("b2b_ready_idle", 32'(req_ready), 32'd1);
    e.addr = 32'h300;
    e.data = 32'h01025A04;
    e.cyc  = cyc + 3;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    serve_read(32'h01020304, 1, 0);
    drain();
    chk("b2b_we_count", 32'(we_cnt - we0), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
